// File: rtl/multiplier_fract.sv
// multiplier_fract: sequential shift-and-add significand multiplier with normalise, guard and sticky outputs
module multiplier_fract #(
    parameter int FRAC_W = 24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_fract_A,
    input  logic [31:0] i_fract_B,
    output logic [31:0] o_fract,
    output logic        o_ovf,
    output logic        o_guard,
    output logic        o_sticky,
    output logic        o_done
);
    localparam int CW = $clog2(FRAC_W);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PREPARE   = 2'd1;
    localparam logic [1:0] EXECUTE   = 2'd2;
    localparam logic [1:0] WRITEBACK = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [FRAC_W-1:0]   a_q, a_d, b_q, b_d, q_q, q_d, fract_q, fract_d;
    logic [2*FRAC_W-1:0] p_q, p_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d, guard_q, guard_d, sticky_q, sticky_d;
    logic [FRAC_W:0]     sum;
    logic                unused_bits;

    assign unused_bits = ^{i_fract_A[31:FRAC_W], i_fract_B[31:FRAC_W]};
    assign sum = {1'b0, p_q[2*FRAC_W-1:FRAC_W]} + {1'b0, q_q[0] ? a_q : '0};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        fract_d  = fract_q;
        ovf_d    = ovf_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        if (state_q == IDLE && i_start) begin
            a_d     = i_fract_A[FRAC_W-1:0];
            b_d     = i_fract_B[FRAC_W-1:0];
            state_d = PREPARE;
        end else if (state_q == PREPARE) begin
            p_d     = '0;
            q_d     = b_q;
            cnt_d   = CW'(FRAC_W - 1);
            state_d = EXECUTE;
        end else if (state_q == EXECUTE) begin
            p_d     = {sum, p_q[FRAC_W-1:1]};
            q_d     = q_q >> 1;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? WRITEBACK : EXECUTE;
        end else if (state_q == WRITEBACK) begin
            // A product >= 2.0 keeps its top W bits; otherwise shift left one to normalise
            ovf_d    = p_q[2*FRAC_W-1];
            fract_d  = p_q[2*FRAC_W-1] ? p_q[2*FRAC_W-1:FRAC_W] : p_q[2*FRAC_W-2:FRAC_W-1];
            guard_d  = p_q[2*FRAC_W-1] ? p_q[FRAC_W-1] : p_q[FRAC_W-2];
            sticky_d = p_q[2*FRAC_W-1] ? |p_q[FRAC_W-2:0] : |p_q[FRAC_W-3:0];
            state_d  = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            fract_q  <= '0;
            ovf_q    <= 1'b0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            fract_q  <= fract_d;
            ovf_q    <= ovf_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_fract  = {{(32-FRAC_W){1'b0}}, fract_q};
    assign o_ovf    = ovf_q;
    assign o_guard  = guard_q;
    assign o_sticky = sticky_q;
    assign o_done   = (state_q == IDLE);
endmodule

// File: tb/tb_multiplier_fract.sv
// tb_multiplier_fract: randomized and directed checks of multiplier_fract against an arithmetic product model
module tb_multiplier_fract;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] fa = '0, fb = '0;
    logic [31:0] fract;
    logic        ovf, guard, sticky, done;
    int          checks = 0;
    int          errors = 0;

    multiplier_fract #(.FRAC_W(24)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_fract_A(fa), .i_fract_B(fb),
        .o_fract(fract), .o_ovf(ovf), .o_guard(guard), .o_sticky(sticky), .o_done(done)
    );

    always #5 clk = ~clk;

    // Expected {ovf, guard, sticky, fract} from the exact 48-bit product
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p, fr, g, s;
        logic ov;
        p  = longint'(a[23:0]) * longint'(b[23:0]);
        ov = (p >= 64'h8000_0000_0000);
        fr = ov ? (p >> 24) : (p >> 23);
        g  = ov ? ((p >> 23) & 1) : ((p >> 22) & 1);
        s  = ov ? (p % (64'd1 << 23)) : (p % (64'd1 << 22));
        return {ov, g[0], (s != 0), 32'(fr)};
    endfunction

    // Start one op and return the number of edges after acceptance until done rises
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        fa = a; fb = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; fa = $urandom; fb = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done && lat < 60);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done, ovf, guard, sticky, fract} !== {1'b1, 3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset: got done=%b ovf=%b g=%b s=%b fract=%h, want 1 0 0 0 00000000",
                     done, ovf, guard, sticky, fract);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] va[4] = '{32'h00800000, 32'h00FFFFFF, 32'h00C00000, 32'hFF800001};
        logic [31:0] vb[4] = '{32'h00800000, 32'h00FFFFFF, 32'h00C00000, 32'h00800000};
        logic [34:0] want[4] = '{{3'b000, 32'h00800000}, {3'b101, 32'h00FFFFFE},
                                 {3'b100, 32'h00900000}, {3'b000, 32'h00800001}};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], lat);
            checks++;
            if (lat !== 26) begin
                errors++;
                $display("FAIL directed%0d latency: got %0d want 26", i, lat);
            end
            checks++;
            if ({ovf, guard, sticky, fract} !== want[i]) begin
                errors++;
                $display("FAIL directed%0d result: got %h want %h", i, {ovf, guard, sticky, fract}, want[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [34:0] exp;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom;
            if (i % 2 == 0) begin a[23] = 1'b1; b[23] = 1'b1; end
            if (i == 5) a = 32'hFF000000;
            exp = model(a, b);
            do_op(a, b, lat);
            checks++;
            if (lat !== 26 || {ovf, guard, sticky, fract} !== exp) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h: got lat=%0d res=%h want lat=26 res=%h",
                         i, a, b, lat, {ovf, guard, sticky, fract}, exp);
            end
        end
    endtask

    task automatic test_start_ignored;
        @(negedge clk);
        fa = 32'h00C00000; fb = 32'h00C00000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL busy_done: got %b want 0", done);
        end
        repeat (5) @(posedge clk);
        #1; fa = 32'h00FFFFFF; fb = 32'h00FFFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if ({done, ovf, guard, sticky, fract} !== {1'b1, 3'b100, 32'h00900000}) begin
            errors++;
            $display("FAIL ignored_start result: got done=%b res=%h want 1 %h",
                     done, {ovf, guard, sticky, fract}, {3'b100, 32'h00900000});
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || fract !== 32'h00900000) begin
                errors++;
                $display("FAIL no_second_op cycle%0d: got done=%b fract=%h want 1 00900000", i, done, fract);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        fa = 32'h00FFFFFF; fb = 32'h00FFFFFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++;
        if ({done, ovf, guard, sticky, fract} !== {1'b1, 3'b000, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: got done=%b res=%h want 1 %h", done, {ovf, guard, sticky, fract}, 35'h0);
        end
        do_op(32'h00800000, 32'h00800000, lat);
        checks++;
        if (lat !== 26 || {ovf, guard, sticky, fract} !== {3'b000, 32'h00800000}) begin
            errors++;
            $display("FAIL after_reset_op: got lat=%0d res=%h want lat=26 res=%h",
                     lat, {ovf, guard, sticky, fract}, {3'b000, 32'h00800000});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        logic [34:0] exp;
        int lat;
        for (int i = 0; i < 6; i++) begin
            a = $urandom | 32'h00800000; b = (i == 3) ? 32'h0 : ($urandom | 32'h00800000);
            exp = model(a, b);
            fa = a; fb = b; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!done && lat < 60);
            checks++;
            if (lat !== 26 || {ovf, guard, sticky, fract} !== exp) begin
                errors++;
                $display("FAIL back_to_back%0d: got lat=%0d res=%h want lat=26 res=%h",
                         i, lat, {ovf, guard, sticky, fract}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
